// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : owns the PC, issues imem reads and buffers returning words
//                   in a 2-entry skid buffer ahead of a valid/ready decode port.
// Revision 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  busy,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] c_start_pc = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_end_pc   = ADDR_WIDTH'(END_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    inflight_v_q;
  logic [ADDR_WIDTH-1:0]   inflight_pc_q;
  logic [1:0]              occ_q, occ_d;
  logic [DATA_WIDTH-1:0]   buf_data_q [2];
  logic [ADDR_WIDTH-1:0]   buf_pc_q   [2];
  logic                    busy_q, halted_q;

  logic                    w_pop;
  logic                    w_redirect;
  logic                    w_issue;
  logic                    w_push;
  logic [1:0]              w_occ_after_pop;
  logic [2:0]              w_credit;

  assign w_pop           = (occ_q != 2'd0) && instr_ready;
  assign w_redirect      = redirect_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
  // Slots already committed: buffered words plus the read in flight, minus what leaves now.
  assign w_credit        = {1'b0, occ_q} + {2'b00, inflight_v_q} - {2'b00, w_pop};
  assign w_issue         = (state_q == S_RUN) && !redirect_valid && (w_credit < 3'd2);
  assign w_push          = inflight_v_q && !w_redirect;
  assign w_occ_after_pop = occ_q - {1'b0, w_pop};
  assign occ_d           = w_redirect ? 2'd0 : (w_occ_after_pop + {1'b0, w_push});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (w_redirect) begin
      state_d = S_RUN;
      pc_d    = redirect_addr;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_d = S_RUN;
            pc_d    = c_start_pc;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
            if (pc_q == c_end_pc) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((occ_q == 2'd0) && !inflight_v_q) state_d = S_HALT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= c_start_pc;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= 2'd0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_pc_q[0]   <= '0;
      buf_pc_q[1]   <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      occ_q        <= occ_d;
      inflight_v_q <= w_issue;
      if (w_issue) inflight_pc_q <= pc_q;
      busy_q   <= (state_d == S_RUN) || (state_d == S_DRAIN);
      halted_q <= (state_d == S_HALT);
      if (w_pop) begin
        buf_data_q[0] <= buf_data_q[1];
        buf_pc_q[0]   <= buf_pc_q[1];
      end
      // The returning word lands behind whatever survives this cycle's pop.
      if (w_push) begin
        assert (w_occ_after_pop < 2'd2);
        if (w_occ_after_pop == 2'd0) begin
          buf_data_q[0] <= imem_data;
          buf_pc_q[0]   <= inflight_pc_q;
        end else begin
          buf_data_q[1] <= imem_data;
          buf_pc_q[1]   <= inflight_pc_q;
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = (occ_q != 2'd0);
  assign instr_data  = buf_data_q[0];
  assign instr_pc    = buf_pc_q[0];
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : directed and randomized checks of fetch_sequencer
//                      against an address-order reference model.
// Revision 1.0
// ============================================================================
module tb_fetch_sequencer;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int START = 0;
  localparam int END   = 5;
  localparam int DEPTH = 1 << AW;

  typedef enum {M_STREAM, M_DRAINTAIL, M_STOPPED} mode_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          busy;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .START_ADDR(START),
    .END_ADDR  (END)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .busy          (busy),
    .halted        (halted)
  );

  function automatic logic [DW-1:0] memf(input int a);
    logic [31:0] ua;
    ua = a;
    return 32'hC0DE_0000 ^ (ua * 32'h9E37_79B1);
  endfunction

  // Synchronous-read instruction memory: word for the address seen at the previous edge.
  always @(posedge clk) imem_data <= memf(int'(imem_addr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (imem_addr !== AW'(START)) begin n_fail++; $display("FAIL reset_addr: got %0d want %0d", imem_addr, START); end
    n_checks++; if (instr_data !== '0 || instr_pc !== '0) begin n_fail++; $display("FAIL reset_head: got data %h pc %0d want 0/0", instr_data, instr_pc); end
    n_checks++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_status: got busy %b halted %b want 0/0", busy, halted); end
    rst_n = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = AW'(20);
    repeat (4) tick();
    redirect_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== AW'(START)) begin
      n_fail++; $display("FAIL idle_redirect_ignored: got valid %b busy %b addr %0d want 0/0/%0d", instr_valid, busy, imem_addr, START);
    end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL start_edge: got busy %b valid %b want 1/0", busy, instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL start_latency1: got valid %b want 0", instr_valid); end
    tick();
    for (int i = START; i <= END; i++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr_data !== memf(i)) begin
        n_fail++; $display("FAIL stream_word: got valid %b pc %0d data %h want 1/%0d/%h", instr_valid, instr_pc, instr_data, i, memf(i));
      end
      tick();
    end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_past_end: got valid %b pc %0d want 0", instr_valid, instr_pc); end
    for (int k = 0; k < 4 && halted !== 1'b1; k++) tick();
    n_checks++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stream_halt: got halted %b busy %b want 1/0", halted, busy); end
  endtask

  task automatic test_stall();
    int exp = START;
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0; tick(); tick();
    for (int c = 0; c < 40 && exp <= END; c++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(exp) || instr_data !== memf(exp)) begin
        n_fail++; $display("FAIL stall_word: got valid %b pc %0d data %h want 1/%0d/%h", instr_valid, instr_pc, instr_data, exp, memf(exp));
      end
      instr_ready = !(c >= 2 && c < 7);
      if (instr_ready) exp++;
      tick();
    end
    instr_ready = 1'b1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra_word: got valid %b pc %0d want 0", instr_valid, instr_pc); end
    for (int k = 0; k < 4 && halted !== 1'b1; k++) tick();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stall_halt: got halted %b want 1", halted); end
  endtask

  task automatic test_redirect();
    int exp = 40;
    int delivered = 0;
    instr_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== AW'(START)) begin n_fail++; $display("FAIL redir_prefill: got valid %b pc %0d want 1/%0d", instr_valid, instr_pc, START); end
    redirect_valid = 1'b1; redirect_addr = AW'(40); tick(); redirect_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || imem_addr !== AW'(40)) begin n_fail++; $display("FAIL redir_flush: got valid %b addr %0d want 0/40", instr_valid, imem_addr); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_latency1: got valid %b pc %0d want 0", instr_valid, instr_pc); end
    tick();
    for (int c = 0; c < 150 && delivered == 0; c++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(exp) || instr_data !== memf(exp)) begin
        n_fail++; $display("FAIL redir_word: got valid %b pc %0d data %h want 1/%0d/%h", instr_valid, instr_pc, instr_data, exp, memf(exp));
      end
      instr_ready = ($urandom_range(0, 2) != 0);
      if (instr_ready) begin
        if (exp == END) delivered = 1;
        exp = (exp + 1) % DEPTH;
      end
      tick();
    end
    instr_ready = 1'b1;
    n_checks++; if (delivered != 1) begin n_fail++; $display("FAIL redir_timeout: stream did not reach end address, got next pc %0d", exp); end
    for (int k = 0; k < 4 && halted !== 1'b1; k++) tick();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_halt: got halted %b valid %b want 1/0", halted, instr_valid); end
  endtask

  task automatic test_drain_stall();
    instr_ready = 1'b1; start = 1'b1; tick(); start = 1'b0; tick(); tick();
    for (int i = START; i < 4; i++) begin
      n_checks++; if (instr_pc !== AW'(i) || instr_valid !== 1'b1) begin n_fail++; $display("FAIL drain_lead: got valid %b pc %0d want 1/%0d", instr_valid, instr_pc, i); end
      tick();
    end
    instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (halted !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== AW'(4)) begin
        n_fail++; $display("FAIL drain_hold: got halted %b busy %b valid %b pc %0d want 0/1/1/4", halted, busy, instr_valid, instr_pc);
      end
    end
    instr_ready = 1'b1; tick();
    n_checks++; if (instr_pc !== AW'(5) || instr_valid !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL drain_last: got valid %b pc %0d halted %b want 1/5/0", instr_valid, instr_pc, halted); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got valid %b want 0", instr_valid); end
    for (int k = 0; k < 4 && halted !== 1'b1; k++) tick();
    n_checks++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_halt: got halted %b busy %b want 1/0", halted, busy); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0; tick();
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== AW'(START) || busy !== 1'b0 || halted !== 1'b0 || instr_pc !== '0 || instr_data !== '0) begin
      n_fail++; $display("FAIL midreset_state: got valid %b addr %0d busy %b halted %b pc %0d data %h want 0/%0d/0/0/0/0", instr_valid, imem_addr, busy, halted, instr_pc, instr_data, START);
    end
    rst_n = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got valid %b busy %b want 0/0", instr_valid, busy); end
    end
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    for (int i = START; i <= END; i++) begin
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== AW'(i) || instr_data !== memf(i)) begin
        n_fail++; $display("FAIL midreset_resume: got valid %b pc %0d data %h want 1/%0d/%h", instr_valid, instr_pc, instr_data, i, memf(i));
      end
      tick();
    end
    for (int k = 0; k < 4 && halted !== 1'b1; k++) tick();
  endtask

  task automatic test_random();
    mode_t mode = M_STOPPED;
    int    exp = START;
    int    since = 2;
    logic  exp_v;
    logic  pop;
    for (int c = 0; c < 1500; c++) begin
      exp_v = (mode == M_STREAM) && (since >= 2);
      n_checks++;
      if (instr_valid !== exp_v) begin
        n_fail++; $display("FAIL rand_valid: cycle %0d got %b want %b (pc %0d)", c, instr_valid, exp_v, instr_pc);
      end else if (exp_v && (instr_pc !== AW'(exp) || instr_data !== memf(exp))) begin
        n_fail++; $display("FAIL rand_head: cycle %0d got pc %0d data %h want %0d/%h", c, instr_pc, instr_data, exp, memf(exp));
      end
      n_checks++;
      if (busy !== (mode != M_STOPPED) || halted !== (mode == M_STOPPED)) begin
        n_fail++; $display("FAIL rand_status: cycle %0d got busy %b halted %b want %b/%b", c, busy, halted, mode != M_STOPPED, mode == M_STOPPED);
      end
      instr_ready    = ($urandom_range(0, 2) != 0);
      start          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_addr  = AW'($urandom_range(0, DEPTH - 1));
      pop = exp_v && instr_ready;
      if (since < 2) since++;
      if (mode != M_STOPPED && redirect_valid) begin
        mode = M_STREAM; exp = int'(redirect_addr); since = 0;
      end else if (mode == M_STREAM && pop) begin
        if (exp == END) mode = M_DRAINTAIL;
        exp = (exp + 1) % DEPTH;
      end else if (mode == M_DRAINTAIL) begin
        mode = M_STOPPED;
      end else if (mode == M_STOPPED && start) begin
        mode = M_STREAM; exp = START; since = 0;
      end
      tick();
    end
    start = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_drain_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
